// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with table-init FSM, speculative GHR and perf counters
module gshare_predictor #(
  parameter int IDX_W    = 10,
  parameter int HIST_W   = 8,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_pc,
  input  logic              spec_push,
  output logic              pred_taken,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic [HIST_W-1:0] pred_ghr,
  output logic              ready,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic [CTR_W-1:0]  upd_ctr,
  input  logic              upd_taken,
  input  logic              upd_mispred,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_mispred
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_init_ptr;
  logic [HIST_W-1:0]   r_ghr;
  logic                r_ready;
  logic [31:0]         r_stat_lookups;
  logic [31:0]         r_stat_mispred;
  logic [CTR_W-1:0]    r_pht [DEPTH];

  logic                w_run;
  logic [IDX_W-1:0]    w_ridx;
  logic [IDX_W-1:0]    w_widx;
  logic [CTR_W-1:0]    w_rd_ctr;
  logic [CTR_W-1:0]    w_upd_next;
  logic                w_pht_we;
  logic [IDX_W-1:0]    w_pht_waddr;
  logic [CTR_W-1:0]    w_pht_wdata;
  logic [HIST_W-1:0]   w_ghr_repair;
  logic [HIST_W-1:0]   w_ghr_spec;
  logic                w_unused_bits;

  assign w_run    = (r_state == S_RUN);
  assign w_ridx   = if_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_widx   = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
  assign w_rd_ctr = r_pht[w_ridx];

  // Table contents are undefined until init finishes, so mask the read path.
  assign pred_ctr     = r_ready ? w_rd_ctr : '0;
  assign pred_taken   = pred_ctr[CTR_W-1];
  assign pred_ghr     = r_ghr;
  assign ready        = r_ready;
  assign stat_lookups = r_stat_lookups;
  assign stat_mispred = r_stat_mispred;

  // Shift-left form also covers HIST_W=1, where the result is just the new bit.
  assign w_ghr_repair = (upd_ghr << 1) | HIST_W'(upd_taken);
  assign w_ghr_spec   = (r_ghr << 1) | HIST_W'(pred_taken);

  always_comb begin
    w_upd_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) w_upd_next = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) w_upd_next = upd_ctr - CTR_W'(1);
    end
  end

  assign w_pht_we    = !w_run || upd_valid;
  assign w_pht_waddr = w_run ? w_widx : r_init_ptr;
  assign w_pht_wdata = w_run ? w_upd_next : CTR_INIT;

  always_ff @(posedge clk) begin
    if (w_pht_we) r_pht[w_pht_waddr] <= w_pht_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_INIT;
      r_init_ptr     <= '0;
      r_ghr          <= '0;
      r_ready        <= 1'b0;
      r_stat_lookups <= '0;
      r_stat_mispred <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_ptr <= r_init_ptr + IDX_W'(1);
          if (r_init_ptr == '1) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (upd_valid && upd_mispred) r_ghr <= w_ghr_repair;
          else if (spec_push)           r_ghr <= w_ghr_spec;
          if (spec_push)                r_stat_lookups <= r_stat_lookups + 32'd1;
          if (upd_valid && upd_mispred) r_stat_mispred <= r_stat_mispred + 32'd1;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign w_unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        spec_push;
  logic        pred_taken;
  logic [1:0]  pred_ctr;
  logic [7:0]  pred_ghr;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic [1:0]  upd_ctr;
  logic        upd_taken;
  logic        upd_mispred;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        do_upd;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic [1:0]  upd_ctr;
    logic        upd_taken;
    logic [31:0] rd_pc;
    logic [1:0]  exp_ctr;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[9];

  gshare_predictor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_pc        (if_pc),
    .spec_push    (spec_push),
    .pred_taken   (pred_taken),
    .pred_ctr     (pred_ctr),
    .pred_ghr     (pred_ghr),
    .ready        (ready),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_ghr      (upd_ghr),
    .upd_ctr      (upd_ctr),
    .upd_taken    (upd_taken),
    .upd_mispred  (upd_mispred),
    .stat_lookups (stat_lookups),
    .stat_mispred (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check_pop(input string name, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %0h", name, act);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
    end
  endtask

  task automatic clear_upd();
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_ctr = '0;
    upd_taken = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [7:0] ghr, input logic [1:0] ctr,
                           input logic tk, input logic mp);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr = ghr; upd_ctr = ctr;
    upd_taken = tk; upd_mispred = mp;
  endtask

  // Waits for ready; optionally pulses an update and spec_push deep inside INIT.
  task automatic wait_ready(input logic pulse, output int n);
    n = 0;
    while (!ready && n < 2000) begin
      if (pulse && n == 1000) begin
        drive_upd(32'h0, 8'h00, 2'b11, 1'b1, 1'b1);
        spec_push = 1'b1;
      end else begin
        clear_upd();
        spec_push = 1'b0;
      end
      tick();
      n++;
    end
    clear_upd();
    spec_push = 1'b0;
  endtask

  initial begin
    int n;

    vecs[0] = '{1'b1, 32'h100, 8'h00, 2'b01, 1'b1, 32'h100, 2'b10, 1'b1};
    vecs[1] = '{1'b1, 32'h100, 8'h00, 2'b10, 1'b1, 32'h100, 2'b11, 1'b1};
    vecs[2] = '{1'b1, 32'h100, 8'h00, 2'b11, 1'b1, 32'h100, 2'b11, 1'b1};
    vecs[3] = '{1'b1, 32'h200, 8'h00, 2'b00, 1'b0, 32'h200, 2'b00, 1'b0};
    vecs[4] = '{1'b1, 32'h204, 8'h00, 2'b10, 1'b0, 32'h204, 2'b01, 1'b0};
    vecs[5] = '{1'b1, 32'h208, 8'h00, 2'b01, 1'b0, 32'h208, 2'b00, 1'b0};
    vecs[6] = '{1'b1, 32'h20C, 8'h00, 2'b11, 1'b0, 32'h20C, 2'b10, 1'b1};
    vecs[7] = '{1'b0, 32'h000, 8'h00, 2'b00, 1'b0, 32'h3F8, 2'b01, 1'b0};
    vecs[8] = '{1'b1, 32'h000, 8'h05, 2'b01, 1'b1, 32'h014, 2'b10, 1'b1};

    rst_n = 1'b0;
    if_pc = 32'h100;
    spec_push = 1'b0;
    clear_upd();
    #3;
    push_exp(0); check_pop("reset_ready", {31'b0, ready});
    push_exp(0); check_pop("reset_pred_ctr", {30'b0, pred_ctr});
    push_exp(0); check_pop("reset_pred_taken", {31'b0, pred_taken});
    push_exp(0); check_pop("reset_pred_ghr", {24'b0, pred_ghr});
    push_exp(0); check_pop("reset_stat_lookups", stat_lookups);
    push_exp(0); check_pop("reset_stat_mispred", stat_mispred);

    // Reset mid-INIT at cycle 500, then a full init with an ignored update pulse.
    tick();
    rst_n = 1'b1;
    repeat (500) tick();
    push_exp(0); check_pop("init_ready_at_500", {31'b0, ready});
    rst_n = 1'b0;
    #1;
    push_exp(0); check_pop("midinit_reset_ready", {31'b0, ready});
    tick();
    rst_n = 1'b1;
    wait_ready(1'b1, n);
    push_exp(1024); check_pop("init_cycles", n);

    if_pc = 32'h0;
    @(negedge clk);
    push_exp(2'b01); check_pop("init_ignored_upd_ctr", {30'b0, pred_ctr});
    push_exp(0); check_pop("init_ignored_ghr", {24'b0, pred_ghr});
    push_exp(0); check_pop("init_ignored_lookups", stat_lookups);
    push_exp(0); check_pop("init_ignored_mispred", stat_mispred);
    tick();
    if_pc = 32'h1234;
    @(negedge clk);
    push_exp(2'b01); check_pop("init_any_pc_ctr", {30'b0, pred_ctr});
    push_exp(0); check_pop("init_any_pc_taken", {31'b0, pred_taken});

    // Table-driven training and saturation with GHR=0.
    for (int i = 0; i < 9; i++) begin
      tick();
      if (vecs[i].do_upd) drive_upd(vecs[i].upd_pc, vecs[i].upd_ghr, vecs[i].upd_ctr, vecs[i].upd_taken, 1'b0);
      if_pc = 32'hFFC;
      tick();
      clear_upd();
      if_pc = vecs[i].rd_pc;
      push_exp({30'b0, vecs[i].exp_ctr});
      push_exp({31'b0, vecs[i].exp_taken});
      @(negedge clk);
      check_pop($sformatf("vec%0d_ctr", i), {30'b0, pred_ctr});
      check_pop($sformatf("vec%0d_taken", i), {31'b0, pred_taken});
    end

    // GHR: repair to 0x0F, speculative push, then push overridden by repair.
    tick();
    drive_upd(32'h800, 8'h07, 2'b01, 1'b1, 1'b1);
    tick();
    clear_upd();
    if_pc = 32'h13C;
    @(negedge clk);
    push_exp(8'h0F); check_pop("ghr_repair_0f", {24'b0, pred_ghr});
    push_exp(1); check_pop("ghr_0f_pred_taken", {31'b0, pred_taken});
    tick();
    spec_push = 1'b1;
    tick();
    spec_push = 1'b0;
    @(negedge clk);
    push_exp(8'h1F); check_pop("ghr_spec_1f", {24'b0, pred_ghr});
    push_exp(1); check_pop("lookups_1", stat_lookups);
    tick();
    spec_push = 1'b1;
    drive_upd(32'h800, 8'hA0, 2'b01, 1'b0, 1'b1);
    tick();
    spec_push = 1'b0;
    clear_upd();
    @(negedge clk);
    push_exp(8'h40); check_pop("ghr_repair_wins_40", {24'b0, pred_ghr});
    push_exp(2); check_pop("lookups_2", stat_lookups);
    push_exp(2); check_pop("mispred_2", stat_mispred);
    tick();
    drive_upd(32'h800, 8'h40, 2'b01, 1'b1, 1'b0);
    tick();
    clear_upd();
    @(negedge clk);
    push_exp(8'h40); check_pop("ghr_hold", {24'b0, pred_ghr});
    push_exp(2); check_pop("mispred_hold", stat_mispred);

    // Collision: restore GHR=0, then update and read the same index together.
    tick();
    drive_upd(32'hFFC, 8'h00, 2'b01, 1'b0, 1'b1);
    tick();
    drive_upd(32'h300, 8'h00, 2'b01, 1'b1, 1'b0);
    if_pc = 32'h300;
    @(negedge clk);
    push_exp(0); check_pop("collision_ghr0", {24'b0, pred_ghr});
    push_exp(2'b01); check_pop("collision_old", {30'b0, pred_ctr});
    tick();
    clear_upd();
    @(negedge clk);
    push_exp(2'b10); check_pop("collision_new", {30'b0, pred_ctr});

    // Asynchronous reset mid-RUN, then re-init clears training.
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(0); check_pop("async_reset_ready", {31'b0, ready});
    push_exp(0); check_pop("async_reset_ctr", {30'b0, pred_ctr});
    push_exp(0); check_pop("async_reset_lookups", stat_lookups);
    push_exp(0); check_pop("async_reset_mispred", stat_mispred);
    tick();
    rst_n = 1'b1;
    wait_ready(1'b0, n);
    push_exp(1024); check_pop("reinit_cycles", n);
    if_pc = 32'h100;
    @(negedge clk);
    push_exp(2'b01); check_pop("reinit_ctr", {30'b0, pred_ctr});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
